// File: rtl/vecmat_result_pack.sv
// vecmat_result_pack
// Collects the scalar results of the vecmat dot-product engines and packs
// DEPTH consecutive elements into one row vector (element i at bits
// [i*DATA_WIDTH +: DATA_WIDTH]), then offers the row downstream.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. Valid never depends combinationally on ready; once out_valid is
// raised, out_vector/out_len hold until the row is taken.
//
// Optional feature: define VECMAT_PACK_RELU_EN to clamp negative elements to
// zero as they are written into the fill buffer.
//
// FSM: FILL collects elements; HOLD keeps a completed row in the fill buffer
// while the output register is still occupied. The current state is visible
// on the internal signal "state" for checkers.

module vecmat_result_pack #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          flush,
    output logic [DATA_WIDTH*DEPTH-1:0]   out_vector,
    output logic [LEN_WIDTH-1:0]          out_len,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int ROW_W = DATA_WIDTH * DEPTH;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state;
    logic [ROW_W-1:0]     fill_buf;
    logic [ROW_W-1:0]     next_buf;
    logic [IDX_W-1:0]     wr_idx;
    logic [LEN_WIDTH-1:0] hold_len;
    logic [LEN_WIDTH-1:0] close_len;
    logic [DATA_WIDTH-1:0] store_data;
    logic                 accept;
    logic                 slot_free;
    logic                 close;

    // Value written into the fill buffer for an accepted element.
    always_comb begin
`ifdef VECMAT_PACK_RELU_EN
        store_data = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
        store_data = in_data;
`endif
    end

    // Accept/close decisions and the fill buffer including any same-cycle element.
    always_comb begin
        accept    = in_valid && in_ready && (state == FILL);
        slot_free = !out_valid || out_ready;
        next_buf  = fill_buf;
        if (accept) begin
            next_buf[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH] = store_data;
        end
        close_len = LEN_WIDTH'(wr_idx) + LEN_WIDTH'(accept);
        close     = (state == FILL) &&
                    ((accept && (wr_idx == IDX_W'(DEPTH - 1))) ||
                     (flush && ((wr_idx != '0) || accept)));
    end

    // Fill/hold state machine with registered in_ready and output row register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= FILL;
            fill_buf   <= '0;
            wr_idx     <= '0;
            hold_len   <= '0;
            in_ready   <= 1'b0;
            out_vector <= '0;
            out_len    <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (close && slot_free) begin
                        // Row goes straight to the output register.
                        out_vector <= next_buf;
                        out_len    <= close_len;
                        out_valid  <= 1'b1;
                        fill_buf   <= '0;
                        wr_idx     <= '0;
                        in_ready   <= 1'b1;
                    end else if (close) begin
                        // Output still occupied: park the row and stall input.
                        fill_buf <= next_buf;
                        hold_len <= close_len;
                        wr_idx   <= '0;
                        in_ready <= 1'b0;
                        state    <= HOLD;
                    end else begin
                        fill_buf <= next_buf;
                        if (accept) begin
                            wr_idx <= wr_idx + IDX_W'(1);
                        end
                        in_ready <= 1'b1;
                        if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        out_vector <= fill_buf;
                        out_len    <= hold_len;
                        out_valid  <= 1'b1;
                        fill_buf   <= '0;
                        in_ready   <= 1'b1;
                        state      <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vecmat_result_pack.sv
// tb_vecmat_result_pack
// Directed scenarios followed by randomized traffic. A row-level reference
// model (the current partial row plus a queue of closed rows awaiting
// downstream) predicts in_ready, out_valid, out_len and out_vector every cycle.
// Build with +define+VECMAT_PACK_RELU_EN to exercise the clamping variant.

module tb_vecmat_result_pack;

    localparam int W     = 16;
    localparam int D     = 32;
    localparam int LW    = 6;
    localparam int ROW_W = W * D;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]     in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             flush = 1'b0;
    logic [ROW_W-1:0] out_vector;
    logic [LW-1:0]    out_len;
    logic             out_valid;
    logic             out_ready = 1'b0;

    vecmat_result_pack #(.DATA_WIDTH(W), .DEPTH(D), .LEN_WIDTH(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_vector (out_vector),
        .out_len    (out_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0]     cur_q[$];       // elements of the row being filled
    logic [ROW_W-1:0] exp_q[$];       // closed rows not yet taken downstream
    logic [LW-1:0]    exp_len_q[$];
    logic             ready_m = 1'b0;

    function automatic logic [W-1:0] model_store(input logic [W-1:0] d);
`ifdef VECMAT_PACK_RELU_EN
        return d[W-1] ? '0 : d;
`else
        return d;
`endif
    endfunction

    always @(posedge clk) begin
        logic [ROW_W-1:0] row;
        if (!reset) begin
            cur_q.delete();
            exp_q.delete();
            exp_len_q.delete();
            ready_m = 1'b0;
        end else begin
            if (exp_q.size() > 0 && out_ready) begin
                void'(exp_q.pop_front());
                void'(exp_len_q.pop_front());
            end
            if (ready_m && in_valid) cur_q.push_back(model_store(in_data));
            if (ready_m && (cur_q.size() == D || (flush && cur_q.size() > 0))) begin
                row = '0;
                for (int i = 0; i < cur_q.size(); i++) row[i*W +: W] = cur_q[i];
                exp_q.push_back(row);
                exp_len_q.push_back(LW'(cur_q.size()));
                cur_q.delete();
            end
            ready_m = (exp_q.size() < 2);
        end
        #1;
        chk("in_ready", ROW_W'(in_ready), ROW_W'(ready_m));
        chk("out_valid", ROW_W'(out_valid), ROW_W'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk("out_len", ROW_W'(out_len), ROW_W'(exp_len_q[0]));
            chk("out_vector", out_vector, exp_q[0]);
        end
    end

    // ---------------- driver tasks (called at negedge) ----------------
    task automatic send(input logic [W-1:0] d, input logic f);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        flush    = f;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            $display("FAIL send_timeout in_ready stuck at 0, required 1 at %0t", $time);
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [ROW_W-1:0] e;
        logic [79:0]      lanes5;
        logic [63:0]      lanes4;

        // Reset state
        reset = 1'b0;
        idle(2);
        chk("reset_out_valid", ROW_W'(out_valid), '0);
        chk("reset_in_ready", ROW_W'(in_ready), '0);
        chk("reset_out_len", ROW_W'(out_len), '0);
        chk("reset_out_vector", out_vector, '0);
        reset = 1'b1;
        idle(1);
        chk("in_ready_after_reset", ROW_W'(in_ready), ROW_W'(1));

        // Stream a full row with downstream always ready
        out_ready = 1'b1;
        for (int i = 1; i <= 32; i++) send(W'(i), 1'b0);
        chk("stream_valid", ROW_W'(out_valid), ROW_W'(1));
        chk("stream_lane0", ROW_W'(out_vector[15:0]), ROW_W'(16'h0001));
        chk("stream_lane31", ROW_W'(out_vector[511:496]), ROW_W'(16'h0020));
        chk("stream_len", ROW_W'(out_len), ROW_W'(32));
        idle(2);

        // Backpressure: two rows, second parks in the fill buffer
        out_ready = 1'b0;
        for (int i = 1; i <= 64; i++) send(W'(i), 1'b0);
        chk("bp_in_ready_low", ROW_W'(in_ready), '0);
        chk("bp_row1_lane0", ROW_W'(out_vector[15:0]), ROW_W'(16'h0001));
        chk("bp_row1_len", ROW_W'(out_len), ROW_W'(32));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_row2_valid", ROW_W'(out_valid), ROW_W'(1));
        chk("bp_row2_lane0", ROW_W'(out_vector[15:0]), ROW_W'(16'h0021));
        chk("bp_row2_lane31", ROW_W'(out_vector[511:496]), ROW_W'(16'h0040));
        chk("bp_in_ready_back", ROW_W'(in_ready), ROW_W'(1));
        out_ready = 1'b1;
        idle(2);

        // Partial flush with the 5th element, then an empty flush
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        send(16'h3333, 1'b0);
        send(16'h4444, 1'b0);
        send(16'h5555, 1'b1);
        lanes5 = 80'h5555_4444_3333_2222_1111;
        e = '0;
        e[79:0] = lanes5;
        chk("flush_len", ROW_W'(out_len), ROW_W'(5));
        chk("flush_vector", out_vector, e);
        idle(1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("empty_flush_no_row", ROW_W'(out_valid), '0);
        idle(2);

        // Reset in the middle of a row
        for (int i = 0; i < 10; i++) send(W'(16'h00A0 + i), 1'b0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) send(W'(16'h0100 + i), 1'b0);
        chk("rst_mid_valid", ROW_W'(out_valid), ROW_W'(1));
        chk("rst_mid_lane0", ROW_W'(out_vector[15:0]), ROW_W'(16'h0100));
        chk("rst_mid_len", ROW_W'(out_len), ROW_W'(32));
        idle(2);

        // Negative elements, closed by a standalone flush
        send(16'h8000, 1'b0);
        send(16'hFFFF, 1'b0);
        send(16'h7FFF, 1'b0);
        send(16'h0000, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
`ifdef VECMAT_PACK_RELU_EN
        lanes4 = 64'h0000_7FFF_0000_0000;
`else
        lanes4 = 64'h0000_7FFF_FFFF_8000;
`endif
        chk("neg_len", ROW_W'(out_len), ROW_W'(4));
        chk("neg_lanes", ROW_W'(out_vector[63:0]), ROW_W'(lanes4));
        chk("neg_upper_zero", ROW_W'(out_vector[ROW_W-1:64]), '0);
        idle(2);

        // Randomized traffic in segments with varying downstream pressure
        for (int seg = 0; seg < 4; seg++) begin
            int rdy_pct;
            int flush_div;
            rdy_pct   = (seg == 0) ? 90 : (seg == 1) ? 20 : (seg == 2) ? 60 : 5;
            flush_div = (seg == 2) ? 4 : 16;
            for (int c = 0; c < 1000; c++) begin
                reset     = ($urandom_range(0, 499) != 0);
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = W'($urandom);
                flush     = ($urandom_range(0, flush_div - 1) == 0);
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                @(negedge clk);
            end
        end
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vecmat_result_pack.md
Name: vecmat_result_pack

Overview:
- Collector at the output end of the vecmat dot-product engines.
- Consumes the 16-bit fixed-point scalar stream those engines produce, one result per handshake.
- Packs 32 consecutive results into a 512-bit row vector in the same lane order the vecmat multipliers consume: element i sits at bits [i*16 +: 16].
- Offers the packed row downstream over a valid/ready handshake. This lets one attention stage's outputs feed the next stage's vector input.

Parameters:
- DATA_WIDTH, 16, width of one fixed-point element.
- DEPTH, 32, elements per packed row (power of two, ≥2).
- LEN_WIDTH, 6, width of out_len; must hold DEPTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- in_data  input  DATA_WIDTH  scalar result from the upstream adder tree.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept in_data this cycle (registered).
- flush  input  1  close the current partial row; unused lanes are zero-padded.
- out_vector  output  DATA_WIDTH*DEPTH  packed row.
- out_len  output  LEN_WIDTH  number of valid elements in out_vector, 1..DEPTH.
- out_valid  output  1  out_vector/out_len are valid.
- out_ready  input  1  downstream accepts the row.

Behaviour:
- Interface: reset is synchronous, active-low; clock is clk.
- Reset (reset==0 at an edge):
  - out_valid=0, out_vector=0, out_len=0, in_ready=0.
  - Fill buffer zeroed, wr_idx=0, state=FILL.
  - Aborts any in-progress row or held row; no partial row is emitted.
- First edge with reset==1: in_ready goes to 1.
- Storage:
  - Fill buffer (DEPTH×DATA_WIDTH) plus write index wr_idx (0..DEPTH-1).
  - One output register holding out_vector/out_len.
- Accept: in_valid && in_ready at an edge writes in_data into lane wr_idx, then wr_idx increments.
- Row close is triggered by either:
  - accepting lane DEPTH-1 (len=DEPTH), or
  - flush==1 in FILL with (wr_idx>0 or an accept in the same cycle); len = wr_idx plus 1 if accepting.
- Flush with wr_idx==0 and no accept is ignored.
- Flush and accept on the same edge: the accepted element is included in the closed row.
- Output slot is free when out_valid==0 or out_ready==1.
- Transfer on close with the slot free, all at the same edge:
  - out_vector <= fill buffer including any same-cycle element, unused lanes 0.
  - out_len <= len; out_valid <= 1.
  - Fill buffer cleared; wr_idx <= 0; remain FILL with in_ready stays 1.
- Latency: the last element accepted at edge N → out_valid visible in cycle N+1.
- Close with the slot busy: latch the row in the fill buffer, go to HOLD, in_ready <= 0 at the same edge.
- HOLD: on the first edge where the slot is free, transfer as above, in_ready <= 1, return to FILL. flush is ignored in HOLD.
- Output handshake:
  - out_valid && out_ready at an edge with no transfer → out_valid <= 0; out_vector/out_len hold their values.
  - out_vector/out_len are stable while out_valid && !out_ready.
  - Back-to-back rows are allowed: consuming and loading on the same edge keeps out_valid=1.
- Element data is stored verbatim (two's-complement Q-format); no arithmetic except under the optional feature.

Optional Feature:
- Macro VECMAT_PACK_RELU_EN.
- Defined: each accepted element whose bit DATA_WIDTH-1 is 1 (negative) is stored as 0; non-negative values are stored unchanged. Applied at write into the fill buffer; no added latency.
- Undefined: elements are stored verbatim, negatives included.

Test Plan:
- Reset then stream: hold out_ready=1, send 32 elements 0x0001..0x0020 on consecutive cycles.
  - in_ready stays 1 throughout.
  - out_valid rises the cycle after the 32nd accept.
  - out_vector[15:0]=0x0001, out_vector[511:496]=0x0020, out_len=32.
- Backpressure: out_ready=0, send 64 elements.
  - Row 1 shows on the output; in_ready drops after element 64.
  - out_ready=1 for one cycle → row 1 consumed, row 2 (elements 33..64) loads next edge, in_ready returns to 1.
- Partial flush: send 5 elements 0x1111..0x5555, assert flush with the 5th.
  - out_len=5; lanes 0..4 hold the data, lanes 5..31 are 0.
  - A following flush with no data produces no output.
- Reset mid-row: send 10 elements, pull reset low for one cycle, then send 32 elements 0x0100..0x011F.
  - Only one row is emitted, lane0=0x0100, out_len=32.
- RELU (macro defined): send 0x8000, 0xFFFF, 0x7FFF, 0x0000, then flush.
  - Lanes 0..3 = 0x0000, 0x0000, 0x7FFF, 0x0000; out_len=4.
  - Without the macro, lanes 0..1 read 0x8000 and 0xFFFF.
